bram_read_checker: RTL and testbench

Self-checking monitor that sits directly downstream of the dual-port BRAM stimulus sequencer and the BRAM it drives. It snoops both ports' write commands into a small write log, tracks every read issued, and compares the BRAM's registered read data against the logged value one cycle later. It exposes pass/fail/skip counters and captures the first mismatch for board-level debug display.

---
 rtl/bram_read_checker_if.sv | 23 ++
 rtl/bram_read_checker.sv | 209 ++++++++++++++++++++
 tb/tb_bram_read_checker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_read_checker_if.sv
// Snoop bundle for one dual-port BRAM: both ports' commands plus the registered read data.
// The checker only listens, so its side of the bundle is input-only.
interface bram_read_checker_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;

  modport master (
    output addr_a, addr_b, data_a, data_b, we_a, we_b, q_a, q_b
  );

  modport slave (
    input addr_a, addr_b, data_a, data_b, we_a, we_b, q_a, q_b
  );
endinterface

// File: rtl/bram_read_checker.sv
// Dual-port BRAM read checker: logs recent writes, predicts each read and scores the BRAM's
// registered data one cycle later, keeping saturating counters and the first mismatch.
module bram_read_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LOG_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  bram_read_checker_if.slave    bus,
  output logic [7:0]            pass_count,
  output logic [7:0]            fail_count,
  output logic [7:0]            skip_count,
  output logic                  error,
  output logic                  err_port,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_expected,
  output logic [DATA_WIDTH-1:0] err_actual
);

  localparam int IDX_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state;
  logic       sample;

  logic [LOG_DEPTH-1:0]  log_valid;
  logic [ADDR_WIDTH-1:0] log_addr [LOG_DEPTH];
  logic [DATA_WIDTH-1:0] log_data [LOG_DEPTH];
  logic [IDX_W-1:0]      alloc_ptr;

  logic [LOG_DEPTH-1:0]  nxt_valid;
  logic [ADDR_WIDTH-1:0] nxt_addr [LOG_DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data [LOG_DEPTH];
  logic [IDX_W-1:0]      nxt_ptr;
  logic                  wr_hit;
  logic [IDX_W-1:0]      wr_idx;

  logic                  rd_hit_a, rd_hit_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

  logic                  pend_valid_a, pend_known_a;
  logic [ADDR_WIDTH-1:0] pend_addr_a;
  logic [DATA_WIDTH-1:0] pend_exp_a;
  logic                  pend_valid_b, pend_known_b;
  logic [ADDR_WIDTH-1:0] pend_addr_b;
  logic [DATA_WIDTH-1:0] pend_exp_b;

  logic pass_a, fail_a, skip_a;
  logic pass_b, fail_b, skip_b;
  logic [1:0] pass_inc, fail_inc, skip_inc;

  // The edge that drops enable is still a RUN edge but must not sample new commands.
  assign sample = (state == RUN) && enable;

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Read predictions use the log as it stood before this edge's writes.
  always_comb begin
    rd_hit_a  = 1'b0;
    rd_hit_b  = 1'b0;
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < LOG_DEPTH; i++) begin
      if (!rd_hit_a && log_valid[i] && (log_addr[i] == bus.addr_a)) begin
        rd_hit_a  = 1'b1;
        rd_data_a = log_data[i];
      end
      if (!rd_hit_b && log_valid[i] && (log_addr[i] == bus.addr_b)) begin
        rd_hit_b  = 1'b1;
        rd_data_b = log_data[i];
      end
    end
  end

  // Port A is applied first, so B's search sees A's result and a same-address pair shares one entry.
  always_comb begin
    nxt_valid = log_valid;
    nxt_addr  = log_addr;
    nxt_data  = log_data;
    nxt_ptr   = alloc_ptr;
    wr_hit    = 1'b0;
    wr_idx    = '0;
    if (bus.we_a) begin
      for (int i = 0; i < LOG_DEPTH; i++) begin
        if (!wr_hit && nxt_valid[i] && (nxt_addr[i] == bus.addr_a)) begin
          wr_hit = 1'b1;
          wr_idx = IDX_W'(i);
        end
      end
      if (wr_hit) begin
        nxt_data[wr_idx] = bus.data_a;
      end else begin
        nxt_valid[nxt_ptr] = 1'b1;
        nxt_addr[nxt_ptr]  = bus.addr_a;
        nxt_data[nxt_ptr]  = bus.data_a;
        nxt_ptr            = nxt_ptr + IDX_W'(1);
      end
    end
    wr_hit = 1'b0;
    wr_idx = '0;
    if (bus.we_b) begin
      for (int i = 0; i < LOG_DEPTH; i++) begin
        if (!wr_hit && nxt_valid[i] && (nxt_addr[i] == bus.addr_b)) begin
          wr_hit = 1'b1;
          wr_idx = IDX_W'(i);
        end
      end
      if (wr_hit) begin
        nxt_data[wr_idx] = bus.data_b;
      end else begin
        nxt_valid[nxt_ptr] = 1'b1;
        nxt_addr[nxt_ptr]  = bus.addr_b;
        nxt_data[nxt_ptr]  = bus.data_b;
        nxt_ptr            = nxt_ptr + IDX_W'(1);
      end
    end
  end

  always_comb begin
    skip_a   = pend_valid_a && !pend_known_a;
    pass_a   = pend_valid_a && pend_known_a && (bus.q_a == pend_exp_a);
    fail_a   = pend_valid_a && pend_known_a && (bus.q_a != pend_exp_a);
    skip_b   = pend_valid_b && !pend_known_b;
    pass_b   = pend_valid_b && pend_known_b && (bus.q_b == pend_exp_b);
    fail_b   = pend_valid_b && pend_known_b && (bus.q_b != pend_exp_b);
    pass_inc = {1'b0, pass_a} + {1'b0, pass_b};
    fail_inc = {1'b0, fail_a} + {1'b0, fail_b};
    skip_inc = {1'b0, skip_a} + {1'b0, skip_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      log_valid <= '0;
      log_addr  <= '{default: '0};
      log_data  <= '{default: '0};
      alloc_ptr <= '0;
    end else begin
      state <= enable ? RUN : IDLE;
      if (sample) begin
        log_valid <= nxt_valid;
        log_addr  <= nxt_addr;
        log_data  <= nxt_data;
        alloc_ptr <= nxt_ptr;
      end
    end
  end

  // A read is unpredictable if the other port overwrites the same address on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_a <= 1'b0;
      pend_known_a <= 1'b0;
      pend_addr_a  <= '0;
      pend_exp_a   <= '0;
      pend_valid_b <= 1'b0;
      pend_known_b <= 1'b0;
      pend_addr_b  <= '0;
      pend_exp_b   <= '0;
    end else begin
      pend_valid_a <= sample && !bus.we_a;
      pend_known_a <= rd_hit_a && !(bus.we_b && (bus.addr_b == bus.addr_a));
      pend_addr_a  <= bus.addr_a;
      pend_exp_a   <= rd_data_a;
      pend_valid_b <= sample && !bus.we_b;
      pend_known_b <= rd_hit_b && !(bus.we_a && (bus.addr_a == bus.addr_b));
      pend_addr_b  <= bus.addr_b;
      pend_exp_b   <= rd_data_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count   <= '0;
      fail_count   <= '0;
      skip_count   <= '0;
      error        <= 1'b0;
      err_port     <= 1'b0;
      err_addr     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      pass_count <= sat_add(pass_count, pass_inc);
      fail_count <= sat_add(fail_count, fail_inc);
      skip_count <= sat_add(skip_count, skip_inc);
      error      <= error || fail_a || fail_b;
      if (!error && fail_a) begin
        err_port     <= 1'b0;
        err_addr     <= pend_addr_a;
        err_expected <= pend_exp_a;
        err_actual   <= bus.q_a;
      end else if (!error && fail_b) begin
        err_port     <= 1'b1;
        err_addr     <= pend_addr_b;
        err_expected <= pend_exp_b;
        err_actual   <= bus.q_b;
      end
    end
  end

endmodule

// File: tb/tb_bram_read_checker.sv
// Bench for bram_read_checker: a fixed vector table for the basic flow, directed eviction,
// saturation and reset sequences, then random traffic scored against a write-log model.
module tb_bram_read_checker;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int LOG_DEPTH  = 8;

  logic clk;
  logic reset;
  logic enable;

  logic [7:0]            pass_count, fail_count, skip_count;
  logic                  error, err_port;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [DATA_WIDTH-1:0] err_expected, err_actual;

  int nChecks = 0;
  int nFails  = 0;

  bram_read_checker_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  bram_read_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus.slave),
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .skip_count  (skip_count),
    .error       (error),
    .err_port    (err_port),
    .err_addr    (err_addr),
    .err_expected(err_expected),
    .err_actual  (err_actual)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: write log as an address->data map plus allocation order; eviction drops the oldest allocation.
  logic [DATA_WIDTH-1:0] mMem [int];
  int                    mOrder [$];
  bit                    mRun;
  bit                    pv [2];
  bit                    pk [2];
  int                    pa [2];
  int                    pe [2];
  int                    mPass, mFail, mSkip;
  bit                    mError, mPort;
  int                    mAddr, mExp, mAct;

  task automatic modelReset();
    mMem.delete();
    mOrder.delete();
    mRun = 0;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pk[p] = 0; pa[p] = 0; pe[p] = 0;
    end
    mPass = 0; mFail = 0; mSkip = 0;
    mError = 0; mPort = 0; mAddr = 0; mExp = 0; mAct = 0;
  endtask

  task automatic modelWrite(input int addr, input int data);
    if (mMem.exists(addr)) begin
      mMem[addr] = DATA_WIDTH'(data);
    end else begin
      if (mOrder.size() == LOG_DEPTH) mMem.delete(mOrder.pop_front());
      mOrder.push_back(addr);
      mMem[addr] = DATA_WIDTH'(data);
    end
  endtask

  task automatic modelStep();
    bit we [2];
    int ad [2];
    int da [2];
    int q  [2];
    bit smp;
    we[0] = bus.we_a; we[1] = bus.we_b;
    ad[0] = int'(bus.addr_a); ad[1] = int'(bus.addr_b);
    da[0] = int'(bus.data_a); da[1] = int'(bus.data_b);
    q[0]  = int'(bus.q_a);    q[1]  = int'(bus.q_b);
    for (int p = 0; p < 2; p++) begin
      if (pv[p]) begin
        if (!pk[p]) begin
          if (mSkip < 255) mSkip++;
        end else if (q[p] == pe[p]) begin
          if (mPass < 255) mPass++;
        end else begin
          if (mFail < 255) mFail++;
          if (!mError) begin
            mPort = (p == 1); mAddr = pa[p]; mExp = pe[p]; mAct = q[p];
          end
          mError = 1;
        end
      end
    end
    smp = mRun && enable;
    for (int p = 0; p < 2; p++) begin
      pv[p] = smp && !we[p];
      pa[p] = ad[p];
      pk[p] = mMem.exists(ad[p]) && !(we[1-p] && ad[1-p] == ad[p]);
      pe[p] = pk[p] ? int'(mMem[ad[p]]) : 0;
    end
    if (smp && we[0]) modelWrite(ad[0], da[0]);
    if (smp && we[1]) modelWrite(ad[1], da[1]);
    mRun = enable;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " pass_count"},   int'(pass_count),   mPass);
    checkValue({tag, " fail_count"},   int'(fail_count),   mFail);
    checkValue({tag, " skip_count"},   int'(skip_count),   mSkip);
    checkValue({tag, " error"},        int'(error),        int'(mError));
    checkValue({tag, " err_port"},     int'(err_port),     int'(mPort));
    checkValue({tag, " err_addr"},     int'(err_addr),     mAddr);
    checkValue({tag, " err_expected"}, int'(err_expected), mExp);
    checkValue({tag, " err_actual"},   int'(err_actual),   mAct);
  endtask

  // Inputs change 1 time unit after the edge; the model steps on the edge; outputs are read 1 unit later.
  task automatic applyStimulus(input bit en, input bit wa, input int aa, input int da,
                               input bit wb, input int ab, input int db, input int qa, input int qb);
    enable     = en;
    bus.we_a   = wa;
    bus.addr_a = aa[ADDR_WIDTH-1:0];
    bus.data_a = da[DATA_WIDTH-1:0];
    bus.we_b   = wb;
    bus.addr_b = ab[ADDR_WIDTH-1:0];
    bus.data_b = db[DATA_WIDTH-1:0];
    bus.q_a    = qa[DATA_WIDTH-1:0];
    bus.q_b    = qb[DATA_WIDTH-1:0];
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    #2;
    checkValue({tag, " reset pass_count"},   int'(pass_count),   0);
    checkValue({tag, " reset fail_count"},   int'(fail_count),   0);
    checkValue({tag, " reset skip_count"},   int'(skip_count),   0);
    checkValue({tag, " reset error"},        int'(error),        0);
    checkValue({tag, " reset err_port"},     int'(err_port),     0);
    checkValue({tag, " reset err_addr"},     int'(err_addr),     0);
    checkValue({tag, " reset err_expected"}, int'(err_expected), 0);
    checkValue({tag, " reset err_actual"},   int'(err_actual),   0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit en;
    bit wa; int aa; int da;
    bit wb; int ab; int db;
    int qa; int qb;
    int ePass, eFail, eSkip;
    bit eErr, ePort;
    int eAddr, eExp, eAct;
  } vec_t;

  vec_t vecs [15];

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    bus.we_a   = 1'b0; bus.we_b   = 1'b0;
    bus.addr_a = '0;   bus.addr_b = '0;
    bus.data_a = '0;   bus.data_b = '0;
    bus.q_a    = '0;   bus.q_b    = '0;
    modelReset();

    //            en wa aa  da wb ab  db qa    qb  pass fail skip err port addr exp act
    vecs[0]  = '{1, 0, 0,   0, 0, 0,  0, 0,    0,  0, 0, 0,  0, 0, 0, 0,  0};
    vecs[1]  = '{1, 1, 0,   8, 1, 1, 10, 0,    0,  0, 0, 0,  0, 0, 0, 0,  0};
    vecs[2]  = '{1, 0, 2,   0, 0, 1,  0, 0,    0,  0, 0, 0,  0, 0, 0, 0,  0};
    vecs[3]  = '{1, 1, 0,   9, 1, 1, 11, 0,   10,  1, 0, 1,  0, 0, 0, 0,  0};
    vecs[4]  = '{1, 1, 510, 3, 1, 511,15, 0,   0,  1, 0, 1,  0, 0, 0, 0,  0};
    vecs[5]  = '{1, 0, 510, 0, 0, 1,  0, 0,    0,  1, 0, 1,  0, 0, 0, 0,  0};
    vecs[6]  = '{1, 0, 511, 0, 0, 0,  0, 3,   18,  2, 1, 1,  1, 1, 1, 11, 18};
    vecs[7]  = '{1, 0, 510, 0, 1, 100,7, 15,   9,  4, 1, 1,  1, 1, 1, 11, 18};
    vecs[8]  = '{1, 1, 5,   1, 1, 5,  2, 'h55, 0,  4, 2, 1,  1, 1, 1, 11, 18};
    vecs[9]  = '{1, 0, 5,   0, 1, 7,  0, 0,    0,  4, 2, 1,  1, 1, 1, 11, 18};
    vecs[10] = '{1, 1, 6,   4, 0, 6,  0, 2,    0,  5, 2, 1,  1, 1, 1, 11, 18};
    vecs[11] = '{0, 0, 0,   0, 0, 0,  0, 0,    4,  5, 2, 2,  1, 1, 1, 11, 18};
    vecs[12] = '{0, 0, 0,   0, 0, 0,  0, 0,    0,  5, 2, 2,  1, 1, 1, 11, 18};
    vecs[13] = '{1, 0, 3,   0, 0, 3,  0, 0,    0,  5, 2, 2,  1, 1, 1, 11, 18};
    vecs[14] = '{1, 0, 0,   0, 0, 0,  0, 9,    9,  5, 2, 2,  1, 1, 1, 11, 18};

    #1;
    doReset("init");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].en, vecs[i].wa, vecs[i].aa, vecs[i].da,
                    vecs[i].wb, vecs[i].ab, vecs[i].db, vecs[i].qa, vecs[i].qb);
      checkValue($sformatf("vec%0d pass_count", i),   int'(pass_count),   vecs[i].ePass);
      checkValue($sformatf("vec%0d fail_count", i),   int'(fail_count),   vecs[i].eFail);
      checkValue($sformatf("vec%0d skip_count", i),   int'(skip_count),   vecs[i].eSkip);
      checkValue($sformatf("vec%0d error", i),        int'(error),        int'(vecs[i].eErr));
      checkValue($sformatf("vec%0d err_port", i),     int'(err_port),     int'(vecs[i].ePort));
      checkValue($sformatf("vec%0d err_addr", i),     int'(err_addr),     vecs[i].eAddr);
      checkValue($sformatf("vec%0d err_expected", i), int'(err_expected), vecs[i].eExp);
      checkValue($sformatf("vec%0d err_actual", i),   int'(err_actual),   vecs[i].eAct);
    end

    // Eviction: nine distinct addresses push the first one out of an eight-entry log.
    doReset("evict");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LOG_DEPTH + 1; i++) begin
      applyStimulus(1, 1, 20 + i, 100 + i, 1, 20 + i, 100 + i, 0, 0);
    end
    applyStimulus(1, 0, 20, 0, 0, 28, 0, 0, 0);
    applyStimulus(1, 0, 28, 0, 0, 28, 0, 'h1234, 108);
    checkValue("evict skip_count", int'(skip_count), 1);
    checkValue("evict pass_count", int'(pass_count), 1);
    checkOutput("evict");

    // Saturation: two passing reads per cycle for 150 cycles.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1, 0, 28, 0, 0, 28, 0, 108, 108);
    end
    checkValue("sat pass_count", int'(pass_count), 255);
    checkValue("sat fail_count", int'(fail_count), 0);
    checkOutput("sat");

    // Reset while both ports still have a compare in flight.
    doReset("midstream");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post-reset");

    // Random traffic over a small address pool so hits, evictions and collisions all occur.
    for (int i = 0; i < 600; i++) begin
      bit en;
      int qa, qb;
      en = ($urandom_range(0, 15) != 0);
      qa = (pv[0] && pk[0] && $urandom_range(0, 3) != 0) ? pe[0] : int'($urandom_range(0, 65535));
      qb = (pv[1] && pk[1] && $urandom_range(0, 3) != 0) ? pe[1] : int'($urandom_range(0, 65535));
      applyStimulus(en,
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 11)), int'($urandom_range(0, 65535)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 11)), int'($urandom_range(0, 65535)),
                    qa, qb);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
